// File: rtl/cover_pkg.sv
// Shared constants, state encoding and bit helpers for the toggle-cover collector.
// Default build; define COVER_HIT_CNT_EN in the top to enable the hit counter.
package cover_pkg;

    localparam int COVER_TOTAL_DEF = 8744;
    localparam int IDX_W_DEF       = 14;
    localparam int FIFO_DEPTH_DEF  = 16;
    localparam int NWORDS          = (COVER_TOTAL_DEF + 63) / 64;
    localparam int WORD_AW         = IDX_W_DEF - 6;
    localparam int TAIL_BITS       = COVER_TOTAL_DEF - 64 * (NWORDS - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ,
        SCAN
    } cov_state_t;

    // Mask keeping the low n bits of a bitmap word.
    function automatic logic [63:0] tail_mask(input int n);
        logic [63:0] m;
        if (n >= 64) m = '1;
        else         m = (64'd1 << n) - 64'd1;
        return m;
    endfunction

    localparam logic [63:0] TAIL_MASK = tail_mask(TAIL_BITS);

    // Number of set bits in a 64-bit word.
    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < 64; i++) s = s + 7'(v[i]);
        return s;
    endfunction

    // Position of the lowest set bit (0 when v is zero).
    function automatic logic [5:0] lowest_bit(input logic [63:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) r = 6'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/cover_idx_fifo.sv
// First-word fall-through sync FIFO holding newly covered indices.
// Push is accepted when full if a pop happens in the same cycle.
module cover_idx_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 16
) (
    input  logic         gbl_clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush drops every stored entry at once.
    always_ff @(posedge gbl_clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write, no reset needed on data.
    always_ff @(posedge gbl_clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/toggle_cover_collector.sv
// Collects tagged 64-bit hit vectors into a first-hit bitmap and streams each new index once.
// Optional COVER_HIT_CNT_EN adds a saturating count of all accepted hit bits on cov_hits.
module toggle_cover_collector
    import cover_pkg::*;
#(
    parameter int COVER_TOTAL = COVER_TOTAL_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              gbl_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-7:0]  in_word,
    input  logic [63:0]       in_hits,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [IDX_W:0]    cov_count,
    output logic              err_range,
    output logic [31:0]       cov_hits
);

    localparam int NW   = (COVER_TOTAL + 63) / 64;
    localparam int WA_W = IDX_W - 6;
    localparam int TAIL = COVER_TOTAL - 64 * (NW - 1);

    localparam logic [63:0]     TMASK  = tail_mask(TAIL);
    localparam logic [WA_W-1:0] LAST_W = WA_W'(NW - 1);
    localparam logic [WA_W:0]   NW_EXT = (WA_W + 1)'(NW);

    cov_state_t state;
    cov_state_t state_nx;

    logic [63:0]     bitmap [NW];
    logic [WA_W-1:0] wptr;
    logic [WA_W-1:0] word_q;
    logic [63:0]     hits_q;
    logic [63:0]     rd_q;
    logic [63:0]     pend_q;
    logic [IDX_W:0]  cnt_q;
    logic            err_q;

    logic [63:0] tm_q;
    logic [63:0] new_bits;
    logic        in_range;
    logic        clear_we;
    logic        accept;
    logic        err_set;
    logic        rmw_we;
    logic        push;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    assign tm_q      = (word_q == LAST_W) ? TMASK : '1;
    assign new_bits  = hits_q & ~rd_q & tm_q;
    assign in_range  = ({1'b0, in_word} < NW_EXT);
    assign in_ready  = (state == IDLE);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign cov_count = cnt_q;
    assign err_range = err_q;

    // State register; reset parks the FSM in the clear sweep.
    always_ff @(posedge gbl_clk) begin
        if (!reset) state <= CLEAR;
        else        state <= state_nx;
    end

    // Next-state and per-cycle strobes; clr overrides everything.
    always_comb begin
        state_nx = state;
        clear_we = 1'b0;
        accept   = 1'b0;
        err_set  = 1'b0;
        rmw_we   = 1'b0;
        push     = 1'b0;
        unique case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (wptr == LAST_W) state_nx = IDLE;
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_range) begin
                        accept   = 1'b1;
                        state_nx = READ;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            READ: begin
                rmw_we   = 1'b1;
                state_nx = (new_bits != '0) ? SCAN : IDLE;
            end
            SCAN: begin
                if (!fifo_full) begin
                    push = 1'b1;
                    if ((pend_q & (pend_q - 64'd1)) == '0) state_nx = IDLE;
                end
            end
            default: state_nx = CLEAR;
        endcase
        if (clr) begin
            state_nx = CLEAR;
            push     = 1'b0;
        end
    end

    // Clear-sweep word pointer.
    always_ff @(posedge gbl_clk) begin
        if (!reset || clr)  wptr <= '0;
        else if (clear_we)  wptr <= wptr + 1'b1;
    end

    // Bitmap storage: sweep zeroing or read-modify-write of one word.
    always_ff @(posedge gbl_clk) begin
        if (clear_we)    bitmap[wptr]   <= '0;
        else if (rmw_we) bitmap[word_q] <= rd_q | (hits_q & tm_q);
    end

    // Latch the accepted vector and its registered bitmap word.
    always_ff @(posedge gbl_clk) begin
        if (accept) begin
            word_q <= in_word;
            hits_q <= in_hits;
            rd_q   <= bitmap[in_word];
        end
    end

    // Pending new bits, consumed lowest-first as they are pushed.
    always_ff @(posedge gbl_clk) begin
        if (!reset)      pend_q <= '0;
        else if (rmw_we) pend_q <= new_bits;
        else if (push)   pend_q <= pend_q & (pend_q - 64'd1);
    end

    // Distinct-point counter.
    always_ff @(posedge gbl_clk) begin
        if (!reset || clr) cnt_q <= '0;
        else if (rmw_we)   cnt_q <= cnt_q + (IDX_W + 1)'(popcount64(new_bits));
    end

    // Sticky out-of-range flag survives clr, only reset clears it.
    always_ff @(posedge gbl_clk) begin
        if (!reset)       err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

`ifdef COVER_HIT_CNT_EN
    logic [31:0] hits_cnt_q;
    logic [63:0] tm_in;
    logic [32:0] hits_sum;

    assign tm_in    = (in_word == LAST_W) ? TMASK : '1;
    assign hits_sum = {1'b0, hits_cnt_q} + 33'(popcount64(in_hits & tm_in));
    assign cov_hits = hits_cnt_q;

    // Saturating count of every accepted hit bit, repeats included.
    always_ff @(posedge gbl_clk) begin
        if (!reset || clr) hits_cnt_q <= '0;
        else if (accept)   hits_cnt_q <= hits_sum[32] ? '1 : hits_sum[31:0];
    end
`else
    assign cov_hits = '0;
`endif

    cover_idx_fifo #(
        .W     (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .gbl_clk (gbl_clk),
        .reset   (reset),
        .flush   (clr),
        .push    (push),
        .din     ({word_q, lowest_bit(pend_q)}),
        .pop     (pop),
        .dout    (out_index),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector: vector table plus corner sequences.
// Honors COVER_HIT_CNT_EN when checking cov_hits.
module tb_toggle_cover_collector;

    logic        gbl_clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_word;
    logic [63:0] in_hits;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_index;
    logic [14:0] cov_count;
    logic        err_range;
    logic [31:0] cov_hits;

    int checks = 0;
    int errors = 0;
    longint exp_hits = 0;
    int q[$];

    typedef struct {
        logic [7:0]  word;
        logic [63:0] hits;
        int          n;
        int          first;
        int          last;
        int          cnt;
    } vec_t;

    vec_t tv [7];

    toggle_cover_collector dut (
        .gbl_clk   (gbl_clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_hits   (in_hits),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .cov_count (cov_count),
        .err_range (err_range),
        .cov_hits  (cov_hits)
    );

    initial gbl_clk = 1'b0;
    always #5 gbl_clk = ~gbl_clk;

    // Record every index handed over on the drain port.
    always @(negedge gbl_clk) begin
        if (reset && out_valid && out_ready) q.push_back(int'(out_index));
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint exp_cov_hits();
`ifdef COVER_HIT_CNT_EN
        return exp_hits;
`else
        return 0;
`endif
    endfunction

    task automatic send(input logic [7:0] w, input logic [63:0] h);
        logic [63:0] m;
        for (int k = 0; k < 300; k++) begin
            if (in_ready) break;
            @(posedge gbl_clk); #1;
        end
        chk("send ready", in_ready, 1);
        in_word  = w;
        in_hits  = h;
        in_valid = 1'b1;
        @(posedge gbl_clk); #1;
        in_valid = 1'b0;
        m = (w == 8'd136) ? 64'h0000_00FF_FFFF_FFFF : '1;
        if (w < 8'd137) exp_hits += $countones(h & m);
    endtask

    task automatic wait_done(input string nm);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge gbl_clk); #1;
            if (in_ready && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
    endtask

    task automatic sweep(input string nm);
        int n;
        n = 0;
        while (n < 400) begin
            @(posedge gbl_clk); #1;
            n++;
            if (in_ready) break;
        end
        chk(nm, n, 137);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge gbl_clk); #1;
        clr = 1'b0;
        exp_hits = 0;
    endtask

    initial begin
        int bad;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        in_hits   = '0;
        clr       = 1'b0;
        out_ready = 1'b1;

        tv[0] = '{8'd0,   64'h5,                 2, 0,    2,    2};
        tv[1] = '{8'd0,   64'h5,                 0, 0,    0,    2};
        tv[2] = '{8'd136, '1,                    40, 8704, 8743, 42};
        tv[3] = '{8'd0,   64'hF,                 2, 1,    3,    44};
        tv[4] = '{8'd5,   64'h8000_0000_0000_0001, 2, 320, 383,  46};
        tv[5] = '{8'd136, '1,                    0, 0,    0,    46};
        tv[6] = '{8'd3,   64'h0000_0000_0001_0000, 1, 208, 208,  47};

        repeat (3) @(posedge gbl_clk);
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst cov_count", cov_count, 0);
        chk("rst err_range", err_range, 0);
        chk("rst cov_hits", cov_hits, 0);
        reset = 1'b1;
        sweep("rst sweep");
        chk("idle out_valid", out_valid, 0);

        for (int i = 0; i < 7; i++) begin
            q.delete();
            send(tv[i].word, tv[i].hits);
            wait_done($sformatf("v%0d done", i));
            chk($sformatf("v%0d n", i), q.size(), tv[i].n);
            if (tv[i].n > 0 && q.size() > 0) begin
                chk($sformatf("v%0d first", i), q[0], tv[i].first);
                chk($sformatf("v%0d last", i), q[q.size()-1], tv[i].last);
            end
            chk($sformatf("v%0d cov_count", i), cov_count, tv[i].cnt);
            chk($sformatf("v%0d cov_hits", i), cov_hits, exp_cov_hits());
        end

        // First index appears three cycles after acceptance.
        q.delete();
        out_ready = 1'b0;
        send(8'd7, 64'h1);
        @(posedge gbl_clk); #1;
        chk("lat early", out_valid, 0);
        @(posedge gbl_clk); #1;
        chk("lat valid", out_valid, 1);
        chk("lat index", out_index, 448);
        out_ready = 1'b1;
        wait_done("lat done");
        chk("lat n", q.size(), 1);
        chk("lat cov_count", cov_count, 48);

        // Backpressure: FIFO fills, SCAN stalls, nothing lost.
        q.delete();
        out_ready = 1'b0;
        send(8'd1, '1);
        repeat (40) @(posedge gbl_clk);
        #1;
        chk("bp in_ready", in_ready, 0);
        chk("bp out_valid", out_valid, 1);
        chk("bp head", out_index, 64);
        chk("bp none", q.size(), 0);
        out_ready = 1'b1;
        wait_done("bp done");
        chk("bp n", q.size(), 64);
        bad = 0;
        foreach (q[i]) if (q[i] != 64 + i) bad++;
        chk("bp order", bad, 0);
        chk("bp cov_count", cov_count, 112);

        // clr mid-stream flushes, sweeps, and forgets coverage.
        q.delete();
        send(8'd2, '1);
        repeat (10) @(posedge gbl_clk);
        #1;
        pulse_clr();
        chk("clr out_valid", out_valid, 0);
        chk("clr in_ready", in_ready, 0);
        chk("clr cov_count", cov_count, 0);
        chk("clr partial", (q.size() > 0 && q.size() < 64), 1);
        sweep("clr sweep");
        q.delete();
        send(8'd2, '1);
        wait_done("re2 done");
        chk("re2 n", q.size(), 64);
        if (q.size() == 64) begin
            chk("re2 first", q[0], 128);
            chk("re2 last", q[63], 191);
        end
        chk("re2 cov_count", cov_count, 64);
        chk("re2 cov_hits", cov_hits, exp_cov_hits());
        q.delete();
        send(8'd0, 64'h5);
        wait_done("re0 done");
        chk("re0 n", q.size(), 2);
        chk("re0 cov_count", cov_count, 66);

        // Out-of-range word: sticky flag, dropped, stays ready.
        q.delete();
        send(8'd200, '1);
        chk("oor err", err_range, 1);
        chk("oor in_ready", in_ready, 1);
        repeat (5) @(posedge gbl_clk);
        #1;
        chk("oor out_valid", out_valid, 0);
        chk("oor n", q.size(), 0);
        chk("oor cov_count", cov_count, 66);
        chk("oor cov_hits", cov_hits, exp_cov_hits());
        pulse_clr();
        chk("clr keeps err", err_range, 1);
        chk("clr cov_hits", cov_hits, 0);
        sweep("clr2 sweep");
        reset = 1'b0;
        @(posedge gbl_clk); #1;
        chk("rst2 err", err_range, 0);
        chk("rst2 cov_count", cov_count, 0);
        reset = 1'b1;
        exp_hits = 0;
        sweep("rst2 sweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
